// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and data requesters,
// one transaction in flight. Define ARB_ROUND_ROBIN_EN for round-robin arbitration.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [3:0]        data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [3:0]        mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    typedef enum logic {GRANT_INST, GRANT_DATA} grant_t;

    state_t            state, state_nxt;
    grant_t            grant;
    logic [ADDR_W-1:0] addr_q;
    logic              wr_q;
    logic [3:0]        wstrb_q;
    logic [DATA_W-1:0] wdata_q;
    logic              pick_data;
    logic              accept;

`ifdef ARB_ROUND_ROBIN_EN
    grant_t last_grant;

    // With both requests pending, alternate away from the previous winner.
    always_comb begin
        pick_data = data_req && (!inst_req || last_grant == GRANT_INST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= GRANT_INST;
        end else if (accept) begin
            last_grant <= pick_data ? GRANT_DATA : GRANT_INST;
        end
    end
`else
    always_comb begin
        pick_data = data_req;
    end
`endif

    assign accept = (state == IDLE) && (inst_req || data_req);

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            grant   <= GRANT_INST;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wstrb_q <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                if (pick_data) begin
                    grant   <= GRANT_DATA;
                    addr_q  <= data_addr;
                    wr_q    <= data_wr;
                    wstrb_q <= data_wstrb;
                    wdata_q <= data_wdata;
                end else begin
                    grant   <= GRANT_INST;
                    addr_q  <= inst_addr;
                    wr_q    <= 1'b0;
                    wstrb_q <= '0;
                    wdata_q <= '0;
                end
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no latches are inferred.
    always_comb begin
        state_nxt    = state;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        mem_req      = 1'b0;
        unique case (state)
            IDLE: begin
                if (inst_req || data_req) begin
                    state_nxt = ISSUE;
                    if (pick_data) data_addr_ok = 1'b1;
                    else           inst_addr_ok = 1'b1;
                end
            end
            ISSUE: begin
                mem_req = 1'b1;
                if (mem_addr_ok) state_nxt = WAIT;
            end
            WAIT: begin
                if (mem_data_ok) begin
                    state_nxt = IDLE;
                    if (grant == GRANT_DATA) data_data_ok = 1'b1;
                    else                     inst_data_ok = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Handshakes are silenced while reset is held, whatever the current state.
        if (reset) begin
            inst_addr_ok = 1'b0;
            data_addr_ok = 1'b0;
            inst_data_ok = 1'b0;
            data_data_ok = 1'b0;
            mem_req      = 1'b0;
        end
    end

    assign mem_addr   = addr_q;
    assign mem_wr     = wr_q;
    assign mem_wstrb  = wstrb_q;
    assign mem_wdata  = wdata_q;
    assign inst_rdata = mem_rdata;
    assign data_rdata = mem_rdata;

endmodule
